// File: rtl/irq_timer_cpu_pkg.sv
// ---------------------------------------------------------------------------
// irq_timer_cpu_pkg
// Shared definitions for the interrupt controller / compare timer.
//   - reg_idx_e : register index within the bus window (byte offset / stride)
//   - ctrl_t    : layout of the CTRL register
//   - bit positions and field widths used by the top level
// ---------------------------------------------------------------------------
package irq_timer_cpu_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COMPARE  = 3'd2,
        REG_COUNT    = 3'd3,
        REG_ENABLE   = 3'd4,
        REG_PENDING  = 3'd5,
        REG_STATUS   = 3'd6
    } reg_idx_e;

    // Number of decoded registers; index 7 and beyond read as zero.
    localparam int unsigned NUM_REGS = 7;

    localparam int unsigned CTRL_TIMER_EN_BIT    = 0;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
    localparam int unsigned PENDING_TIMER_BIT    = 0;

    localparam int unsigned PRESCALE_WIDTH = 16;
    localparam int unsigned TIMER_WIDTH    = 32;

    // Packed so that bit 0 = timer_en and bit 1 = auto_reload.
    typedef struct packed {
        logic auto_reload;
        logic timer_en;
    } ctrl_t;

endpackage

// File: rtl/irq_timer_cpu_irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Brings one asynchronous interrupt line into the clk_i domain with a 2-flop
// synchroniser and flags its rising edge for one cycle.
//   clk_i      in  system clock
//   reset_n_i  in  asynchronous active-low reset
//   async_i    in  raw external interrupt line
//   edge_o     out one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync2_d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync2_d_q <= 1'b0;
        end else begin
            sync1_q   <= async_i;
            sync2_q   <= sync1_q;
            sync2_d_q <= sync2_q;
        end
    end

    // A level held high produces a single pulse.
    assign edge_o = sync2_q & ~sync2_d_q;

endmodule

// File: rtl/irq_timer_cpu.sv
// ---------------------------------------------------------------------------
// irq_timer_cpu
// Memory-mapped interrupt controller with a built-in compare timer.
//   clk_i      in  system clock
//   reset_n_i  in  asynchronous active-low reset
//   address_i  in  CPU byte address
//   data_i     in  CPU write data
//   rd_wr_i    in  1 = write strobe
//   data_o     out registered read data (1-cycle latency)
//   irq_src_i  in  asynchronous external interrupt lines
//   irq_o      out registered level interrupt to the CPU
// Register k sits at BaseAddress + k*Address_Wording:
//   0 CTRL  1 PRESCALE  2 COMPARE  3 COUNT  4 ENABLE  5 PENDING(W1C)  6 STATUS
// PENDING bit 0 is the timer, bit i+1 is irq_src_i[i].
// ---------------------------------------------------------------------------
module irq_timer_cpu
    import irq_timer_cpu_pkg::*;
#(
    parameter int unsigned BaseAddress     = 0,
    parameter int unsigned NumSources      = 8,
    parameter int unsigned Address_Wording = 4,
    parameter int unsigned address_width   = 32,
    parameter int unsigned data_width      = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [data_width-1:0]    data_o,
    input  logic [NumSources-1:0]    irq_src_i,
    output logic                     irq_o
);

    localparam int unsigned PW = NumSources + 1;
    localparam logic [address_width-1:0] BASE_ADDR = address_width'(BaseAddress);
    localparam logic [address_width-1:0] STRIDE    = address_width'(Address_Wording);

    // -----------------------------------------------------------------------
    // Register state
    // -----------------------------------------------------------------------
    ctrl_t                     ctrl_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [PRESCALE_WIDTH-1:0] prescaler_q;
    logic [TIMER_WIDTH-1:0]    compare_q;
    logic [TIMER_WIDTH-1:0]    count_q;
    logic [PW-1:0]             enable_q;
    logic [PW-1:0]             pending_q;

    // -----------------------------------------------------------------------
    // Address decode: a hit needs an in-window, stride-aligned address.
    // -----------------------------------------------------------------------
    logic [address_width-1:0] offset;
    logic                     hit;
    reg_idx_e                 idx;

    // NOTE: every signal driven here gets a default at the top of the block,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        offset = address_i - BASE_ADDR;
        hit    = (address_i >= BASE_ADDR)
              && ((offset % STRIDE) == '0)
              && ((offset / STRIDE) < address_width'(NUM_REGS));
        idx    = reg_idx_e'(3'(offset / STRIDE));
    end

    logic [TIMER_WIDTH-1:0] wdata;
    logic wr_sel, wr_ctrl, wr_prescale, wr_compare, wr_count, wr_enable, wr_pending;

    assign wdata       = TIMER_WIDTH'(data_i);
    assign wr_sel      = rd_wr_i && hit;
    assign wr_ctrl     = wr_sel && (idx == REG_CTRL);
    assign wr_prescale = wr_sel && (idx == REG_PRESCALE);
    assign wr_compare  = wr_sel && (idx == REG_COMPARE);
    assign wr_count    = wr_sel && (idx == REG_COUNT);
    assign wr_enable   = wr_sel && (idx == REG_ENABLE);
    assign wr_pending  = wr_sel && (idx == REG_PENDING);

    // -----------------------------------------------------------------------
    // Plain configuration registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= '0;
            enable_q   <= '0;
        end else begin
            if (wr_ctrl)     ctrl_q     <= ctrl_t'(wdata[1:0]);
            if (wr_prescale) prescale_q <= wdata[PRESCALE_WIDTH-1:0];
            if (wr_compare)  compare_q  <= wdata;
            if (wr_enable)   enable_q   <= wdata[PW-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Prescaler and compare timer
    // -----------------------------------------------------------------------
    logic tick;
    logic match;
    logic timer_set;

    assign tick      = ctrl_q.timer_en && (prescaler_q == prescale_q);
    // Compare always uses the pre-edge COUNT, even when the CPU overwrites it.
    assign match     = (count_q == compare_q);
    assign timer_set = tick && match;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prescaler_q <= '0;
            count_q     <= '0;
        end else begin
            // Disabling the timer parks the prescaler at 0 so a re-enable
            // always starts a full prescale period.
            if (!ctrl_q.timer_en || tick) prescaler_q <= '0;
            else                          prescaler_q <= prescaler_q + 1'b1;

            // CPU write beats the timer update; the increment wraps naturally.
            if (wr_count)  count_q <= wdata;
            else if (tick) count_q <= (match && ctrl_q.auto_reload) ? '0 : count_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // External sources
    // -----------------------------------------------------------------------
    logic [NumSources-1:0] src_edge;

    for (genvar i = 0; i < NumSources; i++) begin : g_src
        irq_sync_edge u_sync_edge (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .async_i   (irq_src_i[i]),
            .edge_o    (src_edge[i])
        );
    end

    // -----------------------------------------------------------------------
    // Pending / interrupt output
    // -----------------------------------------------------------------------
    logic [PW-1:0] set_mask;
    logic [PW-1:0] clr_mask;
    logic [PW-1:0] status;

    assign set_mask = {src_edge, timer_set};
    assign clr_mask = wr_pending ? wdata[PW-1:0] : '0;
    assign status   = pending_q & enable_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pending_q <= '0;
            irq_o     <= 1'b0;
        end else begin
            // Set is applied after clear so a colliding event is never lost.
            pending_q <= (pending_q & ~clr_mask) | set_mask;
            irq_o     <= |status;
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (idx)
                REG_CTRL:     rd_val = TIMER_WIDTH'(ctrl_q);
                REG_PRESCALE: rd_val = TIMER_WIDTH'(prescale_q);
                REG_COMPARE:  rd_val = compare_q;
                REG_COUNT:    rd_val = count_q;
                REG_ENABLE:   rd_val = TIMER_WIDTH'(enable_q);
                REG_PENDING:  rd_val = TIMER_WIDTH'(pending_q);
                REG_STATUS:   rd_val = TIMER_WIDTH'(status);
                default:      rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) data_o <= '0;
        else            data_o <= data_width'(rd_val);
    end

endmodule

// File: tb/tb_irq_timer_cpu.sv
// ---------------------------------------------------------------------------
// tb_irq_timer_cpu
// Self-checking bench for irq_timer_cpu. Directed scenarios plus a randomized
// register/interrupt sequence checked against a register-level model.
// ---------------------------------------------------------------------------
module tb_irq_timer_cpu;

    localparam int BASE   = 'h40;
    localparam int STRIDE = 4;
    localparam int NSRC   = 8;

    localparam int R_CTRL     = 0;
    localparam int R_PRESCALE = 1;
    localparam int R_COMPARE  = 2;
    localparam int R_COUNT    = 3;
    localparam int R_ENABLE   = 4;
    localparam int R_PENDING  = 5;
    localparam int R_STATUS   = 6;

    logic            clk_i     = 1'b0;
    logic            reset_n_i = 1'b0;
    logic [31:0]     address_i = '0;
    logic [31:0]     data_i    = '0;
    logic            rd_wr_i   = 1'b0;
    logic [31:0]     data_o;
    logic [NSRC-1:0] irq_src_i = '0;
    logic            irq_o;

    int total = 0;
    int bad   = 0;

    // Register-level model used by the randomized test
    logic [31:0] m_ctrl, m_prescale, m_compare, m_count;
    logic [8:0]  m_enable, m_pending;

    irq_timer_cpu #(
        .BaseAddress     (BASE),
        .NumSources      (NSRC),
        .Address_Wording (STRIDE),
        .address_width   (32),
        .data_width      (32)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .address_i (address_i),
        .data_i    (data_i),
        .rd_wr_i   (rd_wr_i),
        .data_o    (data_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] addr_of(int k);
        return 32'(BASE + k * STRIDE);
    endfunction

    // Inputs change and outputs are sampled 1ns after the active edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(int k, logic [31:0] d);
        address_i = addr_of(k);
        data_i    = d;
        rd_wr_i   = 1'b1;
        step();
        rd_wr_i   = 1'b0;
    endtask

    // data_o after the edge reflects the register state before that edge.
    task automatic rd(int k, output logic [31:0] v);
        address_i = addr_of(k);
        rd_wr_i   = 1'b0;
        step();
        v = data_o;
    endtask

    function automatic logic [31:0] model_reg(int k);
        case (k)
            R_CTRL:     return m_ctrl;
            R_PRESCALE: return m_prescale;
            R_COMPARE:  return m_compare;
            R_COUNT:    return m_count;
            R_ENABLE:   return 32'(m_enable);
            R_PENDING:  return 32'(m_pending);
            R_STATUS:   return 32'(m_pending & m_enable);
            default:    return 32'h0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] v;
        repeat (2) step();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
        reset_n_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rd(k, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", k, v); end
        end
        // Run the timer hard, then reset in the middle of it.
        wr(R_ENABLE, 32'h1);
        wr(R_PRESCALE, 32'h0);
        wr(R_COMPARE, 32'h1);
        wr(R_CTRL, 32'h3);
        repeat (6) step();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL midrun_irq got=%b exp=1", irq_o); end
        address_i = addr_of(R_COUNT);
        step();
        #2 reset_n_i = 1'b0;
        #1;
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL async_reset_data got=%h exp=0", data_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL async_reset_irq got=%b exp=0", irq_o); end
        repeat (2) step();
        reset_n_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            rd(n % 7, v);
            total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_reg%0d got=%h exp=0", n % 7, v); end
            total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL post_reset_irq got=%b exp=0", irq_o); end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_timer_oneshot();
        int p, c, hit_clk;
        logic [31:0] v, e;
        p = 3; c = 5;
        hit_clk = (p + 1) * (c + 1);   // clock on which PENDING[0] sets
        wr(R_PRESCALE, 32'(p));
        wr(R_COMPARE, 32'(c));
        wr(R_COUNT, 32'h0);
        wr(R_ENABLE, 32'h1);
        wr(R_CTRL, 32'h1);
        for (int n = 1; n <= 32; n++) begin
            if (n % 2 == 1) begin
                rd(R_PENDING, v);
                e = ((n - 1) >= hit_clk) ? 32'h1 : 32'h0;
            end else begin
                rd(R_COUNT, v);
                e = 32'((n - 1) / (p + 1));
            end
            total++; if (v !== e) begin bad++; $display("FAIL oneshot_read n=%0d got=%h exp=%h", n, v, e); end
            total++; if (irq_o !== (n >= hit_clk + 1)) begin bad++; $display("FAIL oneshot_irq n=%0d got=%b exp=%b", n, irq_o, n >= hit_clk + 1); end
        end
        wr(R_CTRL, 32'h0);
        wr(R_PENDING, 32'hFFFF_FFFF);
        wr(R_ENABLE, 32'h0);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_auto_reload();
        logic [31:0] v, e;
        wr(R_COUNT, 32'h0);
        wr(R_PRESCALE, 32'h0);
        wr(R_COMPARE, 32'h2);
        wr(R_PENDING, 32'hFFFF_FFFF);
        wr(R_ENABLE, 32'h0);
        wr(R_CTRL, 32'h3);
        for (int n = 1; n <= 9; n++) begin
            rd(R_COUNT, v);
            e = 32'((n - 1) % 3);
            total++; if (v !== e) begin bad++; $display("FAIL reload_count n=%0d got=%h exp=%h", n, v, e); end
        end
        // Read PENDING while clearing it every cycle: it should be seen only
        // on the clocks right after each compare hit.
        for (int n = 10; n <= 21; n++) begin
            address_i = addr_of(R_PENDING);
            data_i    = 32'h1;
            rd_wr_i   = 1'b1;
            step();
            v = data_o;
            e = ((n - 1) % 3 == 0) ? 32'h1 : 32'h0;
            total++; if (v !== e) begin bad++; $display("FAIL reload_pending n=%0d got=%h exp=%h", n, v, e); end
        end
        rd_wr_i = 1'b0;
        wr(R_CTRL, 32'h0);           // last tick happens on this edge (22 % 3 = 1)
        wr(R_PENDING, 32'hFFFF_FFFF);
        for (int n = 0; n < 2; n++) begin
            rd(R_COUNT, v);
            total++; if (v !== 32'h1) begin bad++; $display("FAIL frozen_count got=%h exp=1", v); end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_ext_edge();
        logic [31:0] v, e;
        irq_src_i = '0;
        wr(R_ENABLE, 32'h0);
        wr(R_PENDING, 32'hFFFF_FFFF);
        irq_src_i[2] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            rd(R_PENDING, v);
            e = ((n - 1) >= 3) ? 32'h8 : 32'h0;
            total++; if (v !== e) begin bad++; $display("FAIL ext_pending n=%0d got=%h exp=%h", n, v, e); end
            total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ext_irq_masked n=%0d got=%b exp=0", n, irq_o); end
        end
        wr(R_ENABLE, 32'h8);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ext_irq_lag got=%b exp=0", irq_o); end
        step();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL ext_irq_enabled got=%b exp=1", irq_o); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_w1c_collision();
        logic [31:0] v;
        irq_src_i[2] = 1'b0;
        repeat (4) step();
        wr(R_PENDING, 32'h8);
        irq_src_i[2] = 1'b1;
        repeat (2) step();
        wr(R_PENDING, 32'h8);        // lands on the edge that sets PENDING[3]
        rd(R_PENDING, v);
        total++; if (v !== 32'h8) begin bad++; $display("FAIL w1c_collision got=%h exp=8", v); end
        wr(R_PENDING, 32'h8);
        rd(R_PENDING, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL w1c_clear got=%h exp=0", v); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=0", irq_o); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_bus_decode();
        logic [31:0] v;
        irq_src_i = '0;
        repeat (4) step();
        wr(R_PENDING, 32'hFFFF_FFFF);
        irq_src_i[2] = 1'b1;
        repeat (4) step();
        wr(R_ENABLE, 32'h0C);
        address_i = addr_of(7);
        step();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL read_idx7 got=%h exp=0", data_o); end
        address_i = addr_of(R_STATUS);
        #1;
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL read_latency got=%h exp=0", data_o); end
        step();
        total++; if (data_o !== 32'h8) begin bad++; $display("FAIL read_status got=%h exp=8", data_o); end
        address_i = 32'(BASE - STRIDE);
        step();
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL read_below_base got=%h exp=0", data_o); end
        // Write data presented without the strobe
        address_i = addr_of(R_COMPARE);
        data_i    = 32'hDEAD_BEEF;
        rd_wr_i   = 1'b0;
        step();
        rd(R_COMPARE, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL no_strobe_write got=%h exp=2", v); end
        wr(R_PRESCALE, 32'hABCD_1234);
        rd(R_PRESCALE, v);
        total++; if (v !== 32'h1234) begin bad++; $display("FAIL prescale_width got=%h exp=1234", v); end
        wr(R_STATUS, 32'hFF);
        rd(R_STATUS, v);
        total++; if (v !== 32'h8) begin bad++; $display("FAIL status_ro got=%h exp=8", v); end
        wr(R_CTRL, 32'hFFFF_FFFC);
        rd(R_CTRL, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ctrl_unused_bits got=%h exp=0", v); end
        wr(7, 32'hFFFF_FFFF);
        rd(R_ENABLE, v);
        total++; if (v !== 32'h0C) begin bad++; $display("FAIL undefined_write got=%h exp=c", v); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random();
        logic [31:0] v, d, e;
        logic [NSRC-1:0] mask;
        int op, k;
        irq_src_i = '0;
        repeat (4) step();
        wr(R_CTRL, 32'h0);      m_ctrl     = 32'h0;
        wr(R_PRESCALE, 32'h0);  m_prescale = 32'h0;
        wr(R_COMPARE, 32'h0);   m_compare  = 32'h0;
        wr(R_COUNT, 32'h0);     m_count    = 32'h0;
        wr(R_ENABLE, 32'h0);    m_enable   = 9'h0;
        wr(R_PENDING, 32'hFFFF_FFFF); m_pending = 9'h0;
        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                k = $urandom_range(0, 7);
                d = $urandom;
                if (k == R_CTRL) d[0] = 1'b0;   // keep the timer stopped
                wr(k, d);
                case (k)
                    R_CTRL:     m_ctrl     = d & 32'h2;
                    R_PRESCALE: m_prescale = d & 32'hFFFF;
                    R_COMPARE:  m_compare  = d;
                    R_COUNT:    m_count    = d;
                    R_ENABLE:   m_enable   = d[8:0];
                    R_PENDING:  m_pending  = m_pending & ~d[8:0];
                    default:    ;
                endcase
            end else if (op == 1) begin
                mask = NSRC'($urandom_range(0, 255));
                irq_src_i = mask;
                repeat (3) step();
                irq_src_i = '0;
                repeat (3) step();
                m_pending = m_pending | {mask, 1'b0};
            end else begin
                k = $urandom_range(0, 7);
                rd(k, v);
                e = model_reg(k);
                total++; if (v !== e) begin bad++; $display("FAIL rand_read it=%0d reg=%0d got=%h exp=%h", it, k, v, e); end
                total++; if (irq_o !== (|(m_pending & m_enable))) begin bad++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq_o, |(m_pending & m_enable)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timer_oneshot();
        test_auto_reload();
        test_ext_edge();
        test_w1c_collision();
        test_bus_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
